// File: rtl/jac1_prog_loader_if.sv
// Host byte-stream link into the JAC1 program loader.
//   in_data  : host byte
//   in_valid : host byte valid
//   in_ready : loader can take the byte; transfer on in_valid && in_ready at posedge
// master = host side, slave = loader side.
interface jac1_prog_loader_if #(
  parameter int DataWidth = 8
);
  logic [DataWidth-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/jac1_prog_loader.sv
// JAC1 program loader: parses framed images (HDR, LEN, LEN payload, CHK) from a
// host byte stream, writes payload into program memory, and holds the CPU in
// reset until a frame passes its checksum.
// Ports:
//   clk, sys_res          : clock, synchronous active-high reset
//   host (slave)          : in_data / in_valid / in_ready byte stream
//   mem_we/addr/wdata     : program memory write port, 1-cycle registered
//   cpu_run               : 1 releases the CPU (drives JAC1 sys_res_n)
//   load_err              : last frame failed its checksum
//   busy                  : frame in progress
// Optional: define JAC1_LOADER_ECHO_EN to add echo_data/echo_valid, a
// registered copy of every accepted byte (dropped ones included).
module jac1_prog_loader #(
  parameter int                   DataWidth  = 8,
  parameter int                   AddrWidth  = 8,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter logic [DataWidth-1:0] HeaderByte = 8'hA5
) (
  input  logic                 clk,
  input  logic                 sys_res,
  jac1_prog_loader_if.slave    host,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic                 cpu_run,
  output logic                 load_err,
  output logic                 busy
`ifdef JAC1_LOADER_ECHO_EN
  ,
  output logic [DataWidth-1:0] echo_data,
  output logic                 echo_valid
`endif
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_EVAL, S_DONE, S_ERR
  } state_t;

  state_t               state;
  logic                 rdy;
  logic [DataWidth-1:0] cnt;
  logic [DataWidth-1:0] sum;
  logic [AddrWidth-1:0] addr;
  logic                 acc;
  logic                 is_hdr;

  assign host.in_ready = rdy;
  assign acc           = host.in_valid && rdy;
  assign is_hdr        = (host.in_data == HeaderByte);

  always_ff @(posedge clk) begin
    if (sys_res) begin
      state     <= S_IDLE;
      rdy       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BaseAddr;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      load_err  <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      addr      <= BaseAddr;
    end else begin
      rdy    <= 1'b1;
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (acc && is_hdr) begin
            state    <= S_LEN;
            busy     <= 1'b1;
            cpu_run  <= 1'b0;
            load_err <= 1'b0;
          end
        end
        S_LEN: begin
          if (acc) begin
            // LEN=0 stays 0: the decrement wraps to 255, giving 256 bytes
            // before cnt==1 is seen on the last one.
            cnt   <= host.in_data;
            sum   <= '0;
            addr  <= BaseAddr;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (acc) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= host.in_data;
            sum       <= sum + host.in_data;
            addr      <= addr + AddrWidth'(1);
            cnt       <= cnt - DataWidth'(1);
            if (cnt == DataWidth'(1)) state <= S_CHK;
          end
        end
        S_CHK: begin
          if (acc) begin
            // fold CHK into the sum; a good frame leaves it at zero
            sum   <= sum + host.in_data;
            rdy   <= 1'b0;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          busy <= 1'b0;
          if (sum == '0) begin
            state   <= S_DONE;
            cpu_run <= 1'b1;
          end else begin
            state    <= S_ERR;
            load_err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef JAC1_LOADER_ECHO_EN
  always_ff @(posedge clk) begin
    if (sys_res) begin
      echo_data  <= '0;
      echo_valid <= 1'b0;
    end else begin
      echo_valid <= acc;
      if (acc) echo_data <= host.in_data;
    end
  end
`endif

endmodule

// File: tb/tb_jac1_prog_loader.sv
// Self-checking bench for jac1_prog_loader: frames built in the bench; expected
// memory writes, checksum verdict and handshake timing derived from frame content.
module tb_jac1_prog_loader;
  localparam logic [7:0] HDR  = 8'hA5;
  localparam logic [7:0] BASE = 8'h00;

  logic clk = 1'b0;
  logic sys_res;
  always #5 clk = ~clk;

  jac1_prog_loader_if #(.DataWidth(8)) bus();

  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       cpu_run, load_err, busy;
`ifdef JAC1_LOADER_ECHO_EN
  logic [7:0] echo_data;
  logic       echo_valid;
`endif

  jac1_prog_loader dut (
    .clk       (clk),
    .sys_res   (sys_res),
    .host      (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .load_err  (load_err),
    .busy      (busy)
`ifdef JAC1_LOADER_ECHO_EN
    ,
    .echo_data (echo_data),
    .echo_valid(echo_valid)
`endif
  );

  int vecs = 0;
  int errs = 0;
  logic [15:0] wq[$];   // expected {addr, data} writes in order
  logic [15:0] wexp;
  logic [7:0]  pl[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // write monitor: every strobe must match the next expected write
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wq.size() == 0) chk("extra_write", mem_we, 1'b0);
      else begin
        wexp = wq.pop_front();
        chk("wr_addr", mem_addr, wexp[15:8]);
        chk("wr_data", mem_wdata, wexp[7:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // call at a negedge; returns at the negedge after the transfer edge with
  // in_valid still high
  task automatic send_byte(input logic [7:0] b, output int waited);
    waited = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) chk("accept_timeout", bus.in_ready, 1'b1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic gap_for(input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
    if (g > 0) idle(g);
  endtask

  // gap < 0: random 0..2 idle cycles between bytes; else fixed gap
  task automatic send_frame(input logic [7:0] p[$], input logic [7:0] ck, input int gap);
    int w;
    logic [7:0] s;
    logic ok;
    s = 8'h00;
    for (int i = 0; i < p.size(); i++) begin
      wq.push_back({8'(BASE + i), p[i]});
      s = s + p[i];
    end
    ok = (8'(s + ck) == 8'h00);

    send_byte(HDR, w);
    bus.in_valid = 1'b0;
    chk("hdr_run", cpu_run, 1'b0);
    chk("hdr_err", load_err, 1'b0);
    chk("hdr_busy", busy, 1'b1);

    send_byte(8'(p.size()), w);
    chk("len_stall", w, 0);
    for (int i = 0; i < p.size(); i++) begin
      gap_for(gap);
      send_byte(p[i], w);
      chk("data_stall", w, 0);
      chk("we_lat", mem_we, 1'b1);
      chk("wdata_lat", mem_wdata, p[i]);
    end
    gap_for(gap);
    send_byte(ck, w);
    chk("chk_stall", w, 0);
    bus.in_valid = 1'b0;
    chk("eval_rdy", bus.in_ready, 1'b0);
    chk("eval_busy", busy, 1'b1);
    chk("eval_run", cpu_run, 1'b0);
    @(negedge clk);
    chk("run", cpu_run, ok);
    chk("err", load_err, !ok);
    chk("busy_end", busy, 1'b0);
    chk("rdy_end", bus.in_ready, 1'b1);
    chk("writes_pending", wq.size(), 0);
  endtask

  task automatic junk(input logic [7:0] b, input logic run_exp, input logic err_exp);
    int w;
    send_byte(b, w);
    bus.in_valid = 1'b0;
    chk("junk_busy", busy, 1'b0);
    chk("junk_run", cpu_run, run_exp);
    chk("junk_err", load_err, err_exp);
  endtask

  task automatic check_reset_vals();
    chk("rst_rdy", bus.in_ready, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_run", cpu_run, 1'b0);
    chk("rst_err", load_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
  endtask

  initial begin
    int w;
    logic [7:0] s;
    sys_res      = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    sys_res = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", bus.in_ready, 1'b1);

    // basic good frame, back-to-back
    pl = '{8'h10, 8'h20, 8'h30};
    send_frame(pl, 8'hA0, 0);
    // bad checksum, then good frame
    pl = '{8'h11, 8'h22};
    send_frame(pl, 8'h00, 0);
    junk(8'h77, 1'b0, 1'b1);
    pl = '{8'h05};
    send_frame(pl, 8'hFB, 0);
    // junk in DONE and before header
    junk(8'h00, 1'b1, 1'b0);
    junk(8'hFF, 1'b1, 1'b0);
    junk(8'h5A, 1'b1, 1'b0);
    pl = '{8'h7F};
    send_frame(pl, 8'h81, 0);

    // 256-byte frame, LEN=0
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    send_frame(pl, 8'h80, 0);

    // reset after the 2nd payload byte of a 4-byte frame
    wq.push_back({BASE, 8'hC1});
    wq.push_back({8'(BASE + 1), 8'hC2});
    send_byte(HDR, w);
    send_byte(8'h04, w);
    send_byte(8'hC1, w);
    send_byte(8'hC2, w);
    bus.in_valid = 1'b0;
    sys_res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    chk("abort_writes", wq.size(), 0);
    sys_res = 1'b0;
    @(negedge clk);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(pl, 8'hF6, 3);   // fixed 3-cycle valid gaps

    // randomized frames
    for (int f = 0; f < 15; f++) begin
      int n;
      logic [7:0] ck;
      n = int'($urandom_range(40, 1));
      pl.delete();
      s = 8'h00;
      for (int i = 0; i < n; i++) begin
        pl.push_back(8'($urandom));
        s = s + pl[i];
      end
      ck = ($urandom_range(3, 0) != 0) ? 8'(-s) : 8'($urandom);
      if ($urandom_range(1, 0) == 1) junk(8'h3C, cpu_run, load_err);
      send_frame(pl, ck, -1);
    end

    repeat (3) @(negedge clk);
    chk("final_pending", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
